// File: rtl/mac_array_pkg.sv
// ============================================================================
// Module  : mac_array_pkg
// Brief   : Shared FSM state type and default widths for systolic_mac_array.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mac_array_pkg;

    localparam int c_DEF_ROWS   = 4;
    localparam int c_DEF_COLS   = 4;
    localparam int c_DEF_DATA_W = 8;
    localparam int c_DEF_ACC_W  = 16;
    localparam int c_DEF_KW     = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2,
        DRAIN  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mac_pe.sv
// ============================================================================
// Module  : mac_pe
// Brief   : One systolic MAC cell; a/b pass-through plus in-place accumulator.
//           Saturating accumulate when SYSTOLIC_MAC_SAT_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_pe #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     en,
    input  logic                     load,
    input  logic signed [DATA_W-1:0] a_in,
    input  logic signed [DATA_W-1:0] b_in,
    input  logic signed [ACC_W-1:0]  acc_above,
    output logic signed [DATA_W-1:0] a_out,
    output logic signed [DATA_W-1:0] b_out,
    output logic signed [ACC_W-1:0]  acc
);

    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]    w_prod_ext;
    logic signed [ACC_W-1:0]    w_next;

    assign w_prod     = a_in * b_in;
    assign w_prod_ext = ACC_W'(w_prod);

`ifdef SYSTOLIC_MAC_SAT_EN
    logic signed [ACC_W:0] w_sum;

    // One guard bit: overflow shows as disagreement between the top two bits.
    assign w_sum = (ACC_W+1)'(acc) + (ACC_W+1)'(w_prod_ext);

    always_comb begin
        w_next = w_sum[ACC_W-1:0];
        if (w_sum[ACC_W] != w_sum[ACC_W-1]) begin
            w_next = w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                  : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end
`else
    assign w_next = acc + w_prod_ext;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else if (clr) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else begin
            a_out <= a_in;
            b_out <= b_in;
            if (load) begin
                acc <= acc_above;
            end else if (en) begin
                acc <= w_next;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/systolic_mac_array.sv
// ============================================================================
// Module  : systolic_mac_array
// Brief   : Output-stationary ROWS x COLS systolic matmul engine with skewed
//           input feed and row-by-row result drain. Option: SYSTOLIC_MAC_SAT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module systolic_mac_array
    import mac_array_pkg::*;
#(
    parameter int ROWS   = c_DEF_ROWS,
    parameter int COLS   = c_DEF_COLS,
    parameter int DATA_W = c_DEF_DATA_W,
    parameter int ACC_W  = c_DEF_ACC_W,
    parameter int KW     = c_DEF_KW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [KW-1:0]          k_len,
    input  logic [ROWS*DATA_W-1:0] a_in,
    input  logic [COLS*DATA_W-1:0] b_in,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [COLS*ACC_W-1:0]  c_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   busy
);

    localparam int c_FLUSH_LAST = ROWS + COLS - 2;
    localparam int c_FCW        = $clog2(ROWS + COLS);

    state_t           r_state;
    logic [KW-1:0]    r_cnt;
    logic [KW-1:0]    r_k_len;
    logic [c_FCW-1:0] r_flush;

    logic w_accept;
    logic w_clr;
    logic w_en;
    logic w_load;

    logic signed [DATA_W-1:0] w_a   [ROWS][COLS+1];
    logic signed [DATA_W-1:0] w_b   [ROWS+1][COLS];
    logic signed [ACC_W-1:0]  w_acc [ROWS][COLS];

    assign w_accept = in_valid && (r_state == STREAM);
    assign w_clr    = (r_state == IDLE) && start;
    assign w_en     = (r_state == STREAM) || (r_state == FLUSH);
    assign w_load   = (r_state == DRAIN) && out_ready;

    assign in_ready  = (r_state == STREAM);
    assign out_valid = (r_state == DRAIN);
    assign busy      = (r_state != IDLE);
    assign out_last  = (r_state == DRAIN) && (r_cnt == KW'(ROWS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_k_len <= '0;
            r_flush <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_k_len <= k_len;
                        r_cnt   <= '0;
                        r_flush <= '0;
                        r_state <= (k_len == '0) ? FLUSH : STREAM;
                    end
                end
                STREAM: begin
                    if (w_accept) begin
                        r_cnt <= r_cnt + KW'(1);
                        if (r_cnt == r_k_len - KW'(1)) begin
                            r_state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    // Long enough for the last beat to reach the far corner PE.
                    if (r_flush == c_FCW'(c_FLUSH_LAST)) begin
                        r_cnt   <= '0;
                        r_state <= DRAIN;
                    end else begin
                        r_flush <= r_flush + c_FCW'(1);
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (r_cnt == KW'(ROWS - 1)) begin
                            r_cnt   <= '0;
                            r_state <= IDLE;
                        end else begin
                            r_cnt <= r_cnt + KW'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Row r is delayed r cycles so operands meet at PE(r,c) on the same cycle.
    for (genvar r = 0; r < ROWS; r++) begin : g_a_skew
        logic signed [DATA_W-1:0] w_inj;
        assign w_inj = w_accept ? a_in[r*DATA_W +: DATA_W] : '0;

        if (r == 0) begin : g_direct
            assign w_a[r][0] = w_inj;
        end else begin : g_delay
            logic signed [DATA_W-1:0] r_sk [r];
            always_ff @(posedge clk or posedge rst) begin
                if (rst || w_clr) begin
                    for (int i = 0; i < r; i++) r_sk[i] <= '0;
                end else begin
                    r_sk[0] <= w_inj;
                    for (int i = 1; i < r; i++) r_sk[i] <= r_sk[i-1];
                end
            end
            assign w_a[r][0] = r_sk[r-1];
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_b_skew
        logic signed [DATA_W-1:0] w_inj;
        assign w_inj = w_accept ? b_in[c*DATA_W +: DATA_W] : '0;

        if (c == 0) begin : g_direct
            assign w_b[0][c] = w_inj;
        end else begin : g_delay
            logic signed [DATA_W-1:0] r_sk [c];
            always_ff @(posedge clk or posedge rst) begin
                if (rst || w_clr) begin
                    for (int i = 0; i < c; i++) r_sk[i] <= '0;
                end else begin
                    r_sk[0] <= w_inj;
                    for (int i = 1; i < c; i++) r_sk[i] <= r_sk[i-1];
                end
            end
            assign w_b[0][c] = r_sk[c-1];
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic signed [ACC_W-1:0] w_above;

            if (r == 0) begin : g_top
                assign w_above = '0;
            end else begin : g_inner
                assign w_above = w_acc[r-1][c];
            end

            mac_pe #(
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W)
            ) u_pe (
                .clk       (clk),
                .rst       (rst),
                .clr       (w_clr),
                .en        (w_en),
                .load      (w_load),
                .a_in      (w_a[r][c]),
                .b_in      (w_b[r][c]),
                .acc_above (w_above),
                .a_out     (w_a[r][c+1]),
                .b_out     (w_b[r+1][c]),
                .acc       (w_acc[r][c])
            );
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_cout
        assign c_out[c*ACC_W +: ACC_W] = w_acc[ROWS-1][c];
    end

endmodule

`default_nettype wire

// File: tb/tb_systolic_mac_array.sv
// ============================================================================
// Module  : tb_systolic_mac_array
// Brief   : Table-driven self-checking bench for the 4x4 systolic MAC array.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_systolic_mac_array;

    localparam int c_R = 4;
    localparam int c_C = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  k_len;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] c_out;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int               k;
        logic [15:0][7:0] a;     // a[r*4+k]
        logic [15:0][7:0] b;     // b[k*4+c]
        logic [15:0][15:0] c;    // c[r*4+c]
        bit               gaps;
        bit               junk;
    } vec_t;

    vec_t vecs [6];

    systolic_mac_array dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .k_len     (k_len),
        .a_in      (a_in),
        .b_in      (b_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .c_out     (c_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    function automatic logic [63:0] row_of(input vec_t v, input int r);
        logic [63:0] x;
        for (int c = 0; c < c_C; c++) x[c*16 +: 16] = v.c[r*4+c];
        return x;
    endfunction

    task automatic run_job(input vec_t v, input bit stall);
        int          n;
        logic [63:0] held;
        @(negedge clk);
        start     = 1'b1;
        k_len     = 8'(v.k);
        out_ready = !stall;
        @(negedge clk);
        start = 1'b0;
        chk("in_ready_after_start", 64'(in_ready), 64'(v.k != 0));
        chk("busy_after_start", 64'(busy), 64'd1);
        for (int kk = 0; kk < v.k; kk++) begin
            if (v.gaps) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1;
            for (int r = 0; r < c_R; r++) a_in[r*8 +: 8] = v.a[r*4+kk];
            for (int c = 0; c < c_C; c++) b_in[c*8 +: 8] = v.b[kk*4+c];
            @(negedge clk);
        end
        if (v.junk) begin
            in_valid = 1'b1;
            a_in     = 32'h55555555;
            b_in     = 32'h7F7F7F7F;
        end else begin
            in_valid = 1'b0;
            a_in     = '0;
            b_in     = '0;
        end
        n = 1;
        while (!out_valid && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("first_out_valid_latency", 64'(n), 64'(c_R + c_C));
        if (stall) begin
            held  = c_out;
            start = 1'b1;
            k_len = 8'd2;
            repeat (5) begin
                @(negedge clk);
                chk("stall_out_valid", 64'(out_valid), 64'd1);
                chk("stall_c_out_hold", c_out, held);
            end
            start     = 1'b0;
            out_ready = 1'b1;
        end
        for (int i = 0; i < c_R; i++) begin
            chk("drain_valid", 64'(out_valid), 64'd1);
            chk($sformatf("drain_row_beat%0d", i), c_out, row_of(v, c_R - 1 - i));
            chk($sformatf("drain_last_beat%0d", i), 64'(out_last), 64'(i == c_R - 1));
            @(negedge clk);
        end
        chk("busy_after_drain", 64'(busy), 64'd0);
        chk("out_valid_after_drain", 64'(out_valid), 64'd0);
        in_valid = 1'b0;
        a_in     = '0;
        b_in     = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        // Vector 0: k=1, all 3 -> every element 9
        vecs[0] = '{k: 1, a: '0, b: '0, c: '0, gaps: 0, junk: 0};
        for (int i = 0; i < 16; i++) begin
            vecs[0].a[i] = 8'd3;
            vecs[0].b[i] = 8'd3;
            vecs[0].c[i] = 16'd9;
        end
        // Vector 1: identity A, B = 1..16 -> C = B
        vecs[1] = '{k: 4, a: '0, b: '0, c: '0, gaps: 0, junk: 0};
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                vecs[1].a[r*4+c] = (r == c) ? 8'd1 : 8'd0;
                vecs[1].b[r*4+c] = 8'(r*4 + c + 1);
                vecs[1].c[r*4+c] = 16'(r*4 + c + 1);
            end
        end
        // Vector 2: same with input bubbles and junk on in_valid after STREAM
        vecs[2]      = vecs[1];
        vecs[2].gaps = 1;
        vecs[2].junk = 1;
        // Vector 3: k=3, all 127 -> 48387 wraps to -17149 or saturates
        vecs[3] = '{k: 3, a: '0, b: '0, c: '0, gaps: 0, junk: 0};
        for (int i = 0; i < 16; i++) begin
            vecs[3].a[i] = 8'd127;
            vecs[3].b[i] = 8'd127;
`ifdef SYSTOLIC_MAC_SAT_EN
            vecs[3].c[i] = 16'h7FFF;
`else
            vecs[3].c[i] = 16'hBD03;
`endif
        end
        // Vector 4: k=0 -> zeros
        vecs[4] = '{k: 0, a: '0, b: '0, c: '0, gaps: 0, junk: 0};
        // Vector 5: A rows [-1, 2], B rows [1 2 3 4],[5 6 7 8] -> 9 10 11 12
        vecs[5] = '{k: 2, a: '0, b: '0, c: '0, gaps: 0, junk: 0};
        for (int r = 0; r < 4; r++) begin
            vecs[5].a[r*4+0] = 8'hFF;
            vecs[5].a[r*4+1] = 8'd2;
            for (int c = 0; c < 4; c++) vecs[5].c[r*4+c] = 16'(9 + c);
        end
        for (int c = 0; c < 4; c++) begin
            vecs[5].b[0*4+c] = 8'(c + 1);
            vecs[5].b[1*4+c] = 8'(c + 5);
        end

        rst = 1'b1; start = 1'b0; k_len = '0; a_in = '0; b_in = '0;
        in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_in_ready", 64'(in_ready), 64'd0);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_last", 64'(out_last), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_c_out", c_out, 64'd0);
        rst = 1'b0;

        // Reset in the middle of STREAM
        @(negedge clk);
        start = 1'b1;
        k_len = 8'd4;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        a_in     = 32'h7F7F7F7F;
        b_in     = 32'h7F7F7F7F;
        repeat (2) @(negedge clk);
        chk("pre_rst_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_c_out", c_out, 64'd0);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        a_in     = '0;
        b_in     = '0;

        for (int t = 0; t < 6; t++) run_job(vecs[t], 1'b0);

        // Output back-pressure during DRAIN, with an ignored start
        run_job(vecs[1], 1'b1);
        // Next job after the stalled one still behaves normally
        run_job(vecs[5], 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
